// File: rtl/wide_add_sequencer.sv
// Wide adder that reuses one CHUNK_W-bit slice over NUM_CHUNKS cycles, LS chunk first.
// Define WIDE_ADD_SEQ_SUB_EN to add a 'sub' port giving a - b (cout=1 means no borrow).
module wide_add_sequencer #(
  parameter int CHUNK_W    = 32,
  parameter int NUM_CHUNKS = 4,
  localparam int W         = CHUNK_W * NUM_CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic [CHUNK_W:0]   add_res;

  // The single shared slice: operates on the chunk selected by idx_q.
  assign a_chunk = a_q[int'(idx_q) * CHUNK_W +: CHUNK_W];
  assign b_chunk = b_q[int'(idx_q) * CHUNK_W +: CHUNK_W];
  assign add_res = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK_W + 1)'(carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
`ifdef WIDE_ADD_SEQ_SUB_EN
          // Subtraction as a + ~b + 1: invert b once at capture, seed carry with 1.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q) * CHUNK_W +: CHUNK_W] = add_res[CHUNK_W-1:0];
        carry_d = add_res[CHUNK_W];
        if (idx_q == IDX_W'(NUM_CHUNKS - 1)) begin
          cout_d  = add_res[CHUNK_W];
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: vector table, hand-written corner sequences and a random sweep
// checked against an arithmetic reference model.
module tb_wide_add_sequencer;

  localparam int CHUNK_W    = 32;
  localparam int NUM_CHUNKS = 4;
  localparam int W          = CHUNK_W * NUM_CHUNKS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .sub       (sub_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  typedef struct {
    string        name;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, {cout,sum}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + (W + 1)'(c);
    end
    return r;
  endfunction

  // Called #1 after a posedge with in_ready expected high; returns #1 after the accepting edge.
  task automatic start_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s);
    a        = x;
    b        = y;
    cin      = c;
    sub_in   = s;
    in_valid = 1'b1;
    chk({name, "_in_ready"}, (W + 1)'(in_ready), (W + 1)'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = {4{$urandom()}};
    b        = {4{$urandom()}};
    cin      = ~c;
    sub_in   = ~s;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, (W + 1)'(n), (W + 1)'(NUM_CHUNKS));
  endtask

  task automatic finish_op(input string name, input logic [W-1:0] es, input logic ec);
    chk({name, "_sum"}, (W + 1)'(sum), (W + 1)'(es));
    chk({name, "_cout"}, (W + 1)'(cout), (W + 1)'(ec));
    chk({name, "_no_ready_in_done"}, (W + 1)'(in_ready), (W + 1)'(1'b0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_ready_after"}, (W + 1)'({in_ready, out_valid}), (W + 1)'(2'b10));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input logic [W-1:0] es, input logic ec);
    out_ready = 1'b1;
    start_op(name, x, y, c, s);
    wait_done(name);
    finish_op(name, es, ec);
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub_in    = 1'b0;
    out_ready = 1'b1;

    vecs.push_back('{"simple", 128'd5, 128'd7, 1'b0, 1'b0, 128'd12, 1'b0});
    vecs.push_back('{"ripple_all", {W{1'b1}}, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1});
    vecs.push_back('{"ripple_96", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
                     1'b0, 128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0});
    vecs.push_back('{"ones_ones_c", {W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, {W{1'b1}}, 1'b1});
    vecs.push_back('{"chunk_edge", 128'h0000_0000_0000_0000_8000_0000_8000_0000,
                     128'h8000_0000_0000_0000_8000_0000_8000_0000, 1'b0, 1'b0,
                     128'h8000_0000_0000_0001_0000_0001_0000_0000, 1'b0});
`ifdef WIDE_ADD_SEQ_SUB_EN
    vecs.push_back('{"sub_neg", 128'd3, 128'd5, 1'b0, 1'b1,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"sub_pos", 128'd5, 128'd3, 1'b1, 1'b1, 128'd2, 1'b1});
    vecs.push_back('{"sub_eq", 128'd9, 128'd9, 1'b0, 1'b1, 128'd0, 1'b1});
`endif

    #12;
    chk("reset_in_ready", (W + 1)'(in_ready), (W + 1)'(1'b1));
    chk("reset_out_valid", (W + 1)'(out_valid), (W + 1)'(1'b0));
    chk("reset_sum", (W + 1)'(sum), (W + 1)'(0));
    chk("reset_cout", (W + 1)'(cout), (W + 1)'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
             vecs[i].es, vecs[i].ec);

    // Backpressure: result held while out_ready=0; a pending request is not taken.
    out_ready = 1'b0;
    start_op("bp", 128'd100, 128'd200, 1'b0, 1'b0);
    wait_done("bp");
    a        = 128'd1000;
    b        = 128'd1;
    cin      = 1'b0;
    sub_in   = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {cout, sum}, {1'b0, 128'd300});
      chk("bp_flags", (W + 1)'({out_valid, in_ready}), (W + 1)'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", (W + 1)'({in_ready, out_valid}), (W + 1)'(2'b10));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_accepted", (W + 1)'(in_ready), (W + 1)'(1'b0));
    wait_done("bp_new");
    finish_op("bp_new", 128'd1001, 1'b0);

    // Reset abort after two chunks have been processed.
    start_op("abort", {W{1'b1}}, 128'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_flags", (W + 1)'({in_ready, out_valid}), (W + 1)'(2'b10));
    chk("abort_out", {cout, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_idle", (W + 1)'({in_ready, out_valid}), (W + 1)'(2'b10));
    run_op("after_abort", 128'd1, 128'd1, 1'b0, 1'b0, 128'd2, 1'b0);

    // Random sweep against the arithmetic model, with random consumer stalls.
    for (int t = 0; t < 24; t++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (t % 4 == 0) rb = ~ra;
      rc = 1'($urandom_range(0, 1));
`ifdef WIDE_ADD_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      exp = model(ra, rb, rc, rs);
      out_ready = 1'b0;
      start_op("rand", ra, rb, rc, rs);
      wait_done("rand");
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        @(posedge clk);
        #1;
      end
      finish_op("rand", exp[W-1:0], exp[W]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs a wide addition by reusing a single CHUNK_W-bit ripple-carry adder slice over NUM_CHUNKS cycles, least-significant chunk first.
- The carry is registered between chunks, which trades latency for area.
- Sits between a requester (valid/ready input) and a consumer (valid/ready output). Used wherever a wide add is needed but a full-width carry chain is too costly.

Parameters:
- CHUNK_W, 32: width of the shared adder slice in bits.
- NUM_CHUNKS, 4: number of slices per operand; operand width is W = CHUNK_W*NUM_CHUNKS. Must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request carries valid operands.
- in_ready  output  1  block can accept a request.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into chunk 0.
- out_valid  output  1  sum/cout are final and stable.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result register.
- cout  output  1  carry out of the top chunk.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. in_ready=1, out_valid=0, sum=0, cout=0. Operand registers, chunk index and carry register all cleared.
- Reset mid-RUN or mid-DONE: the operation is aborted and nothing is reported. After release the block is in IDLE.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid&in_ready at an edge: latch a, b, cin; idx<=0; carry<=cin; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle computes {c,s} = a[idx chunk] + b[idx chunk] + carry, as a (CHUNK_W+1)-bit unsigned sum.
  - The chunk s is written into sum[idx*CHUNK_W +: CHUNK_W] and carry<=c.
  - If idx==NUM_CHUNKS-1: cout<=c and go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - When out_ready=1 at an edge: go to IDLE.
  - While out_ready=0, remains in DONE indefinitely.
- Latency: out_valid rises exactly NUM_CHUNKS clock edges after the accepting edge.
- Throughput: one result per NUM_CHUNKS+2 cycles with out_ready held high. No acceptance occurs in the same cycle as result transfer, because in_ready=0 in DONE.
- in_valid during RUN or DONE: ignored; operands are not re-latched. Live changes to a, b or cin after acceptance have no effect.
- sum bits are updated chunkwise during RUN. They are defined only while out_valid=1.
- Arithmetic is unsigned, modulo 2^W; the overflow indication is cout only.
- idx width is max(1, clog2(NUM_CHUNKS)).
- NUM_CHUNKS=1: a single RUN cycle, then DONE.
- out_valid and in_ready are never both 1.

Optional Feature:
- WIDE_ADD_SEQ_SUB_EN defined:
  - Adds input port sub (1 bit), sampled with a at acceptance.
  - sub=1: the latched b is replaced by ~b and carry is initialised to 1 (cin ignored), giving sum = a - b mod 2^W.
  - cout=1 means no borrow (a >= b).
  - sub=0 behaves exactly as add.
- Macro not defined: port sub is absent; the block is add-only.

Test Plan (CHUNK_W=32, NUM_CHUNKS=4, W=128):
- Reset values: assert rst_n=0 -> in_ready=1, out_valid=0, sum=0, cout=0.
- Simple add: accept a=5, b=7, cin=0, out_ready=1 -> out_valid high 4 edges after accept; sum=12, cout=0; in_ready returns 1 one cycle after transfer.
- Full carry ripple across chunks: a=2^128-1, b=0, cin=1 -> sum=0, cout=1. Also a=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x0000_0001_0000_0000_0000_0000_0000_0000, cout=0.
- Backpressure and ignored requests:
  - Hold out_ready=0 for 10 cycles in DONE -> sum/cout stable, out_valid=1 throughout.
  - Drive in_valid with new operands meanwhile -> not accepted.
  - Release out_ready -> IDLE, then the new request is accepted.
- Reset abort: assert rst_n mid-RUN (after 2 chunks) -> outputs return to reset values immediately; the next request a=1, b=1 gives sum=2.
- WIDE_ADD_SEQ_SUB_EN:
  - a=3, b=5, sub=1 -> sum=2^128-2, cout=0.
  - a=5, b=3, sub=1 -> sum=2, cout=1.
